reg_file_shadowed: RTL and testbench
====================================

Name: reg_file_shadowed

Overview:
- Parametrised successor to the core register file. Combinational reads on NRD-independent ports A/B, one clocked write port, optional write-to-read bypass, optional hard-wired zero r0.
- Adds a shadow bank with a multi-cycle save/restore sequencer for fast context swap (interrupt/call entry and exit).
- Sits between the decode stage (read addresses), the writeback mux (write data) and the control unit (save/restore requests, stall on Busy).

Parameters:
W, 8, data path width in bits (1..8)
A, 3, address width; depth N = 2**A registers (1..4)
BYPASS, 1, 1 = a read of the address being written this cycle returns DataIn; 0 = returns stored value
R0_ZERO, 0, 1 = register 0 reads as 0 and ignores all writes, including restore; 0 = r0 is general purpose

Ports:
Clk  input  1  clock, all state updates on rising edge
ResetN  input  1  asynchronous active-low reset
WriteEn  input  1  core write strobe
Waddr  input  A  core write address
DataIn  input  W  core write data
RaddrA  input  A  read address, port A
RaddrB  input  A  read address, port B
DataOutA  output  W  combinational read data, port A
DataOutB  output  W  combinational read data, port B
SaveReq  input  1  request copy of live bank into shadow bank
RestoreReq  input  1  request copy of shadow bank into live bank
Busy  output  1  save/restore in progress
Done  output  1  one-cycle pulse when a sequence completes
WriteDrop  output  1  one-cycle pulse when a core write was discarded because Busy

Behaviour:
- Reset (ResetN low, asynchronous): all live and shadow registers cleared to 0; FSM enters IDLE; idx cleared to 0; Busy=0, Done=0, WriteDrop=0. Reset asserted mid-sequence aborts it immediately, with no partial state retained.
- Reads: both ports behave identically. DataOutX = Live[RaddrX].
  - If R0_ZERO and RaddrX==0: output 0.
  - If BYPASS and an effective core write targets RaddrX this cycle: output DataIn.
- Effective core write: WriteEn and not Busy, and not (R0_ZERO and Waddr==0). It updates Live[Waddr] at the next edge.
- FSM states: IDLE, SAVE, RESTORE. idx is an A-bit counter. Busy = (state != IDLE), decoded from registered state.
- IDLE transitions:
  - SaveReq → SAVE.
  - else RestoreReq → RESTORE.
  - Both requests high together: SAVE wins and RestoreReq is discarded.
  - idx set to 0 on entry.
- SAVE: each edge does Shadow[idx] <= Live[idx] and idx++. The edge that copies idx N-1 returns to IDLE and sets Done=1 for exactly one cycle.
- RESTORE: same sequencing with Live[idx] <= Shadow[idx]. Under R0_ZERO, Live[0] is not written.
- Timing: a request sampled at edge k gives Busy high from edge k to edge k+N, i.e. N cycles. Copies occur at edges k+1..k+N. Done is high in the cycle after edge k+N, and Busy is already low in that cycle.
- SaveReq/RestoreReq while Busy: ignored, not queued.
- A new request may be sampled in the same cycle Done is high; back-to-back sequences are allowed.
- WriteEn while Busy: the write is discarded, the bypass is inactive, and WriteDrop is registered high for the following cycle.
- Reads during Busy return live contents. During RESTORE, partially restored contents are visible; the control unit stalls on Busy.
- Idx wraps naturally at N-1. No other arithmetic is performed.

Test Plan:
- Reset then reads: drive ResetN low mid-run with random data written → all DataOutA/B = 0x00, Busy=0, Done=0 immediately, asynchronously, before the next edge.
- Write/read with bypass: BYPASS=1, write r3=0xA5 with RaddrA=3 in the same cycle → DataOutA=0xA5 that cycle; with BYPASS=0 → old value 0x00 that cycle, 0xA5 next cycle.
- R0_ZERO=1: write r0=0xFF, then restore from a shadow whose r0=0x55 → r0 always reads 0x00.
- Save/restore round trip: load r0..r7=0x10..0x17, SaveReq, overwrite all with 0xEE, RestoreReq.
  - Busy is high for exactly 8 cycles per sequence.
  - Done pulses once per sequence.
  - Final contents are 0x10..0x17.
- Write during Busy: WriteEn r2=0x99 two cycles after SaveReq → WriteDrop=1 next cycle; r2 unchanged; shadow r2 holds the pre-save value.
- Simultaneous SaveReq+RestoreReq in IDLE → SAVE executes (shadow updated, live unchanged). A RestoreReq asserted mid-save is ignored, and exactly one Done is seen.

Source files
------------

// File: rtl/reg_file_shadowed.sv
// rtl/reg_file_shadowed.sv - register file with shadow bank and save/restore sequencer
module reg_file_shadowed #(
  parameter int W       = 8,
  parameter int A       = 3,
  parameter int BYPASS  = 1,
  parameter int R0_ZERO = 0
) (
  input  logic         Clk,
  input  logic         ResetN,
  input  logic         WriteEn,
  input  logic [A-1:0] Waddr,
  input  logic [W-1:0] DataIn,
  input  logic [A-1:0] RaddrA,
  input  logic [A-1:0] RaddrB,
  output logic [W-1:0] DataOutA,
  output logic [W-1:0] DataOutB,
  input  logic         SaveReq,
  input  logic         RestoreReq,
  output logic         Busy,
  output logic         Done,
  output logic         WriteDrop
);

  localparam int N = 2 ** A;
  localparam logic [A-1:0] LAST = A'(N - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SAVE    = 2'd1,
    RESTORE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [A-1:0] idx_q, idx_d;
  logic [W-1:0] live_q   [N];
  logic [W-1:0] shadow_q [N];
  logic         busy;
  logic         seq_last;
  logic         wr_eff;
  logic         done_q;
  logic         drop_q;

  assign busy     = (state_q != IDLE);
  assign seq_last = busy && (idx_q == LAST);
  // Writes are blocked while sequencing; r0 writes vanish when r0 is hard-wired
  assign wr_eff   = WriteEn && !busy && !((R0_ZERO != 0) && (Waddr == '0));

  assign Busy      = busy;
  assign Done      = done_q;
  assign WriteDrop = drop_q;

  // State register and copy index
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state: SAVE has priority; requests while busy are simply not looked at
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (SaveReq) begin
          state_d = SAVE;
        end else if (RestoreReq) begin
          state_d = RESTORE;
        end
      end
      SAVE, RESTORE: begin
        idx_d = idx_q + A'(1);
        if (idx_q == LAST) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Completion and dropped-write pulses, one cycle each
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      done_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      done_q <= seq_last;
      drop_q <= WriteEn && busy;
    end
  end

  // Live bank: restore copies one entry per cycle, otherwise the core write port
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < N; i++) begin
        live_q[i] <= '0;
      end
    end else if (state_q == RESTORE) begin
      if (!((R0_ZERO != 0) && (idx_q == '0))) begin
        live_q[idx_q] <= shadow_q[idx_q];
      end
    end else if (wr_eff) begin
      live_q[Waddr] <= DataIn;
    end
  end

  // Shadow bank: filled one entry per cycle during SAVE
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      for (int i = 0; i < N; i++) begin
        shadow_q[i] <= '0;
      end
    end else if (state_q == SAVE) begin
      shadow_q[idx_q] <= live_q[idx_q];
    end
  end

  function automatic logic [W-1:0] rd_mux(
    input logic [A-1:0] ra,
    input logic [W-1:0] stored,
    input logic         hit,
    input logic [W-1:0] wdata
  );
    if ((R0_ZERO != 0) && (ra == '0)) begin
      return '0;
    end else if ((BYPASS != 0) && hit) begin
      return wdata;
    end else begin
      return stored;
    end
  endfunction

  // Combinational read ports with optional write-through bypass
  always_comb begin
    DataOutA = rd_mux(RaddrA, live_q[RaddrA], wr_eff && (Waddr == RaddrA), DataIn);
    DataOutB = rd_mux(RaddrB, live_q[RaddrB], wr_eff && (Waddr == RaddrB), DataIn);
  end

endmodule

// File: tb/tb_reg_file_shadowed.sv
// tb/tb_reg_file_shadowed.sv - directed self-checking bench for reg_file_shadowed
module tb_reg_file_shadowed;

  logic       Clk;
  logic       ResetN;
  logic       WriteEn;
  logic [2:0] Waddr;
  logic [7:0] DataIn;
  logic [2:0] RaddrA;
  logic [2:0] RaddrB;
  logic       SaveReq;
  logic       RestoreReq;

  // dut: bypass, general r0; dut_nb: no bypass; dut_z: bypass, hard-wired r0
  logic [7:0] oa1, ob1, oa2, ob2, oa3, ob3;
  logic       busy1, done1, drop1;
  logic       busy2, done2, drop2;
  logic       busy3, done3, drop3;

  int n_cmp = 0;
  int n_err = 0;

  reg_file_shadowed #(.W(8), .A(3), .BYPASS(1), .R0_ZERO(0)) dut (
    .Clk(Clk), .ResetN(ResetN), .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
    .RaddrA(RaddrA), .RaddrB(RaddrB), .DataOutA(oa1), .DataOutB(ob1),
    .SaveReq(SaveReq), .RestoreReq(RestoreReq), .Busy(busy1), .Done(done1), .WriteDrop(drop1)
  );

  reg_file_shadowed #(.W(8), .A(3), .BYPASS(0), .R0_ZERO(0)) dut_nb (
    .Clk(Clk), .ResetN(ResetN), .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
    .RaddrA(RaddrA), .RaddrB(RaddrB), .DataOutA(oa2), .DataOutB(ob2),
    .SaveReq(SaveReq), .RestoreReq(RestoreReq), .Busy(busy2), .Done(done2), .WriteDrop(drop2)
  );

  reg_file_shadowed #(.W(8), .A(3), .BYPASS(1), .R0_ZERO(1)) dut_z (
    .Clk(Clk), .ResetN(ResetN), .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
    .RaddrA(RaddrA), .RaddrB(RaddrB), .DataOutA(oa3), .DataOutB(ob3),
    .SaveReq(SaveReq), .RestoreReq(RestoreReq), .Busy(busy3), .Done(done3), .WriteDrop(drop3)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // One write in the current window; returns at the next window with WriteEn low
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    WriteEn = 1'b1;
    Waddr   = a;
    DataIn  = d;
    @(negedge Clk);
    WriteEn = 1'b0;
  endtask

  // Issue a request in the current window, then observe 12 windows of dut
  task automatic seq(input logic sv, input logic rs, input int mid_rest,
                     output int busy_cnt, output int done_cnt, output int done_at);
    SaveReq    = sv;
    RestoreReq = rs;
    @(negedge Clk);
    SaveReq  = 1'b0;
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    for (int c = 0; c < 12; c++) begin
      RestoreReq = (c == mid_rest);
      #1;
      if (busy1) busy_cnt++;
      if (done1) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      @(negedge Clk);
    end
    RestoreReq = 1'b0;
  endtask

  task automatic test_reset;
    ResetN = 1'b0;
    #2;
    for (int i = 0; i < 8; i++) begin
      RaddrA = 3'(i);
      RaddrB = 3'(7 - i);
      #1;
      n_cmp++;
      if (oa1 !== 8'h00 || ob1 !== 8'h00 || oa2 !== 8'h00 || oa3 !== 8'h00) begin
        n_err++;
        $display("FAIL reset_read r%0d: got %h/%h/%h/%h want 00", i, oa1, ob1, oa2, oa3);
      end
    end
    n_cmp++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || drop1 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_status: busy=%b done=%b drop=%b want 0/0/0", busy1, done1, drop1);
    end
    @(negedge Clk);
    ResetN = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_bypass;
    RaddrA = 3'd3;
    WriteEn = 1'b1;
    Waddr   = 3'd3;
    DataIn  = 8'hA5;
    #1;
    n_cmp++;
    if (oa1 !== 8'hA5) begin
      n_err++;
      $display("FAIL bypass_same_cycle: got %h want a5", oa1);
    end
    n_cmp++;
    if (oa2 !== 8'h00) begin
      n_err++;
      $display("FAIL nobypass_same_cycle: got %h want 00", oa2);
    end
    @(negedge Clk);
    WriteEn = 1'b0;
    #1;
    n_cmp++;
    if (oa2 !== 8'hA5 || oa1 !== 8'hA5) begin
      n_err++;
      $display("FAIL write_next_cycle: got %h/%h want a5/a5", oa1, oa2);
    end
    @(negedge Clk);
  endtask

  task automatic test_r0_zero;
    RaddrA = 3'd0;
    RaddrB = 3'd0;
    WriteEn = 1'b1;
    Waddr   = 3'd0;
    DataIn  = 8'hFF;
    #1;
    n_cmp++;
    if (oa3 !== 8'h00 || oa1 !== 8'hFF) begin
      n_err++;
      $display("FAIL r0_write_cycle: got z=%h g=%h want 00/ff", oa3, oa1);
    end
    @(negedge Clk);
    WriteEn = 1'b0;
    #1;
    n_cmp++;
    if (oa3 !== 8'h00 || ob3 !== 8'h00 || oa1 !== 8'hFF) begin
      n_err++;
      $display("FAIL r0_after_write: got z=%h/%h g=%h want 00/00/ff", oa3, ob3, oa1);
    end
    @(negedge Clk);
  endtask

  task automatic test_round_trip;
    int bc, dc, da;
    for (int i = 0; i < 8; i++) wr(3'(i), 8'h10 + 8'(i));
    seq(1'b1, 1'b0, -1, bc, dc, da);
    n_cmp++;
    if (bc !== 8 || dc !== 1 || da !== 8) begin
      n_err++;
      $display("FAIL save_timing: busy=%0d done=%0d at=%0d want 8/1/8", bc, dc, da);
    end
    for (int i = 0; i < 8; i++) wr(3'(i), 8'hEE);
    RaddrA = 3'd4;
    #1;
    n_cmp++;
    if (oa1 !== 8'hEE) begin
      n_err++;
      $display("FAIL overwrite: got %h want ee", oa1);
    end
    seq(1'b0, 1'b1, -1, bc, dc, da);
    n_cmp++;
    if (bc !== 8 || dc !== 1 || da !== 8) begin
      n_err++;
      $display("FAIL restore_timing: busy=%0d done=%0d at=%0d want 8/1/8", bc, dc, da);
    end
    for (int i = 0; i < 8; i++) begin
      RaddrA = 3'(i);
      RaddrB = 3'(7 - i);
      #1;
      n_cmp++;
      if (oa1 !== 8'h10 + 8'(i) || ob1 !== 8'h17 - 8'(i) || oa2 !== 8'h10 + 8'(i) ||
          oa3 !== ((i == 0) ? 8'h00 : 8'h10 + 8'(i))) begin
        n_err++;
        $display("FAIL restore_data r%0d: got %h/%h/%h/%h", i, oa1, ob1, oa2, oa3);
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_write_drop;
    int bc, dc, da;
    wr(3'd2, 8'h42);
    RaddrA = 3'd2;
    SaveReq = 1'b1;
    @(negedge Clk);
    SaveReq = 1'b0;
    @(negedge Clk);
    WriteEn = 1'b1;
    Waddr   = 3'd2;
    DataIn  = 8'h99;
    #1;
    n_cmp++;
    if (oa1 !== 8'h42 || busy1 !== 1'b1) begin
      n_err++;
      $display("FAIL drop_no_bypass: got %h busy=%b want 42/1", oa1, busy1);
    end
    @(negedge Clk);
    WriteEn = 1'b0;
    #1;
    n_cmp++;
    if (drop1 !== 1'b1 || drop3 !== 1'b1) begin
      n_err++;
      $display("FAIL drop_pulse: got %b/%b want 1/1", drop1, drop3);
    end
    @(negedge Clk);
    #1;
    n_cmp++;
    if (drop1 !== 1'b0) begin
      n_err++;
      $display("FAIL drop_clear: got %b want 0", drop1);
    end
    for (int c = 0; c < 12 && busy1; c++) @(negedge Clk);
    @(negedge Clk);
    #1;
    n_cmp++;
    if (busy1 !== 1'b0 || oa1 !== 8'h42) begin
      n_err++;
      $display("FAIL drop_live: busy=%b r2=%h want 0/42", busy1, oa1);
    end
    @(negedge Clk);
    wr(3'd2, 8'h00);
    seq(1'b0, 1'b1, -1, bc, dc, da);
    #1;
    n_cmp++;
    if (oa1 !== 8'h42) begin
      n_err++;
      $display("FAIL drop_shadow: got %h want 42", oa1);
    end
    @(negedge Clk);
  endtask

  task automatic test_simultaneous;
    int bc, dc, da;
    wr(3'd5, 8'h77);
    seq(1'b1, 1'b1, 3, bc, dc, da);
    n_cmp++;
    if (bc !== 8 || dc !== 1 || da !== 8) begin
      n_err++;
      $display("FAIL simul_timing: busy=%0d done=%0d at=%0d want 8/1/8", bc, dc, da);
    end
    RaddrA = 3'd5;
    #1;
    n_cmp++;
    if (oa1 !== 8'h77) begin
      n_err++;
      $display("FAIL simul_live: got %h want 77", oa1);
    end
    @(negedge Clk);
    wr(3'd5, 8'h00);
    seq(1'b0, 1'b1, -1, bc, dc, da);
    #1;
    n_cmp++;
    if (oa1 !== 8'h77) begin
      n_err++;
      $display("FAIL simul_shadow: got %h want 77", oa1);
    end
    @(negedge Clk);
  endtask

  task automatic test_back_to_back;
    int bc, dc, d1, d2;
    bit issued;
    bc = 0; dc = 0; d1 = -1; d2 = -1; issued = 0;
    SaveReq = 1'b1;
    @(negedge Clk);
    SaveReq = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (busy1) bc++;
      if (done1) begin
        dc++;
        if (d1 < 0) d1 = c; else d2 = c;
      end
      RestoreReq = done1 && !issued;
      if (done1) issued = 1;
      @(negedge Clk);
      RestoreReq = 1'b0;
    end
    n_cmp++;
    if (bc !== 16 || dc !== 2 || d1 !== 8 || d2 !== 17) begin
      n_err++;
      $display("FAIL back_to_back: busy=%0d done=%0d at=%0d,%0d want 16/2/8,17", bc, dc, d1, d2);
    end
  endtask

  task automatic test_reset_mid;
    int bc, dc, da;
    wr(3'd1, 8'h3C);
    RaddrA = 3'd1;
    RaddrB = 3'd7;
    SaveReq = 1'b1;
    @(negedge Clk);
    SaveReq = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    #2;
    ResetN = 1'b0;
    #1;
    n_cmp++;
    if (busy1 !== 1'b0 || done1 !== 1'b0 || drop1 !== 1'b0 || oa1 !== 8'h00 || ob1 !== 8'h00) begin
      n_err++;
      $display("FAIL reset_mid: busy=%b done=%b drop=%b a=%h b=%h want 0/0/0/00/00",
               busy1, done1, drop1, oa1, ob1);
    end
    @(negedge Clk);
    ResetN = 1'b1;
    @(negedge Clk);
    seq(1'b0, 1'b1, -1, bc, dc, da);
    n_cmp++;
    if (bc !== 8 || dc !== 1) begin
      n_err++;
      $display("FAIL reset_restore_timing: busy=%0d done=%0d want 8/1", bc, dc);
    end
    for (int i = 0; i < 8; i++) begin
      RaddrA = 3'(i);
      #1;
      n_cmp++;
      if (oa1 !== 8'h00 || oa2 !== 8'h00) begin
        n_err++;
        $display("FAIL reset_shadow r%0d: got %h/%h want 00", i, oa1, oa2);
      end
      @(negedge Clk);
    end
  endtask

  initial begin
    ResetN = 1'b0;
    WriteEn = 1'b0;
    Waddr = '0;
    DataIn = '0;
    RaddrA = '0;
    RaddrB = '0;
    SaveReq = 1'b0;
    RestoreReq = 1'b0;
    @(negedge Clk);
    test_reset;
    test_bypass;
    test_r0_zero;
    test_round_trip;
    test_write_drop;
    test_simultaneous;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
